sample_window: RTL and testbench
================================

# sample_window

Front-end stage of the midterm filter datapath. Collects a 16-sample frame of signed 32-bit input, then sweeps the frame one output position per handshake. For each position it presents the centre sample, the three samples on each side, and the 4-bit position index `count`. It feeds the neighbour-sum stage directly, which consumes `count`, `dataP1..3` and `dataM1..3` unchanged.

## Interface
- `DW`, default 32: sample width, signed two's complement.
- `N`, default 16: frame length. Fixed at 16 because `count` is 4 bits; other values are unsupported.
- `clk` input 1: clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: input sample valid.
- `in_data` input DW: input sample.
- `in_ready` output 1: block can accept a sample. Equals (state == LOAD).
- `out_valid` output 1: output tap set is valid.
- `out_ready` input 1: downstream accepts the tap set.
- `count_o` output 4: position index n of the current tap set.
- `data0_o` output DW: x[n].
- `dataP1_o`, `dataP2_o`, `dataP3_o` output DW each: x[n+1], x[n+2], x[n+3]. Driven 0 when the index is above 15.
- `dataM1_o`, `dataM2_o`, `dataM3_o` output DW each: x[n-1], x[n-2], x[n-3]. Driven 0 when the index is below 0.
- `last_o` output 1: high with the tap set for n = 15.
- `done_o` output 1: one-cycle pulse after the last tap set is accepted.

## Operation
- Storage: 16 × DW buffer `mem`, 4-bit write pointer `wr_ptr`, 5-bit read index `rd_idx`.
- States: LOAD, SWEEP, DRAIN. Reset state is LOAD.
- LOAD:
  - An input beat transfers when `in_valid && in_ready`.
  - Each transfer writes `mem[wr_ptr] <= in_data` and increments `wr_ptr`.
  - The transfer at `wr_ptr == 15` moves the state to SWEEP, sets `wr_ptr` to 0 and `rd_idx` to 0.
  - Gaps in `in_valid` pause the load and lose nothing.
- SWEEP: the output register is free when `!out_valid || out_ready`. When free:
  - Load all tap outputs for n = `rd_idx`.
  - Set `out_valid` to 1 and increment `rd_idx`.
  - Set `last_o` to (n == 15). When n = 15 is loaded, the state moves to DRAIN.
- DRAIN:
  - On `out_valid && out_ready`: clear `out_valid` and `last_o`, pulse `done_o`, move to LOAD.
- Outputs are registered and hold stable while `out_valid && !out_ready`.
- Out-of-range taps are forced to 0 inside this block, so the downstream zero-masking is redundant but harmless.
- Data is passed bit-exact. No arithmetic, no extension, no saturation.
- `in_valid` outside LOAD is ignored. `mem` is not written outside LOAD.
- `out_ready` outside SWEEP/DRAIN is ignored.

## Timing
- Reset values: all data outputs 0, `count_o` 0, `out_valid` 0, `last_o` 0, `done_o` 0.
  - After reset: state LOAD, `wr_ptr` 0, `rd_idx` 0.
  - `mem` contents are not reset and are don't-care until reloaded.
- `rst` overrides everything on the same edge, including mid-load and mid-sweep. A partial frame is discarded.
- With `out_ready` held high, edges are numbered from E0, the edge that accepts the 16th sample:
  - E0: state becomes SWEEP.
  - E1: the n = 0 tap set appears with `out_valid` = 1.
  - E1 to E16: n = 0..15 appear on consecutive cycles.
  - E16: state becomes DRAIN.
  - E17: `done_o` = 1 for one cycle, `in_ready` = 1.
- Throughput: 16 load cycles + 17 sweep cycles per frame with no stalls.
- Fully registered outputs. There is no combinational path from `out_ready` to the data outputs. `in_ready` depends on state only.

## Test plan
- **Ramp frame:** load x[i] = i+1 with `out_ready` = 1.
  - n = 0: data0 = 1, P1/P2/P3 = 2/3/4, M1..M3 = 0.
  - n = 2: M1 = 2, M2 = 1, M3 = 0.
  - n = 15: data0 = 16, M1/M2/M3 = 15/14/13, P1..P3 = 0, `last_o` = 1.
  - `done_o` pulses one cycle after n = 15 is accepted.
- **Backpressure:** drop `out_ready` for 3 cycles while n = 5 is presented.
  - `count_o` = 5 and all taps stay stable.
  - The sweep resumes at n = 6 with no skipped or duplicated index. Total accepted beats = 16.
- **Sparse input:** toggle `in_valid` 1/0 during load.
  - `in_ready` stays 1 for the whole load.
  - SWEEP starts the edge after the 16th accepted beat.
  - Output matches the ramp case.
- **Foreign input:** drive `in_valid` = 1 with 0xDEADBEEF throughout SWEEP.
  - `in_ready` = 0 throughout.
  - The swept frame is unchanged.
  - The next frame starts cleanly at `wr_ptr` 0.
- **Reset mid-sweep:** assert `rst` one cycle at n = 7.
  - Next cycle: all outputs 0, `out_valid` 0, `in_ready` 1.
  - A new frame of x[i] = 100+i sweeps correctly from n = 0.
- **Extreme values:** load alternating 0x80000000 and 0x7FFFFFFF.
  - All taps reproduce the input bit-exact.
  - Back-to-back frames produce two full sweeps, each followed by `done_o`.

Source files
------------

// File: rtl/sample_window.sv
// sample_window: buffers a 16-sample frame, then sweeps it one position per
// handshake, presenting the centre sample with three neighbours on each side.
module sample_window #(
    parameter int DW = 32,
    parameter int N  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    count_o,
    output logic [DW-1:0] data0_o,
    output logic [DW-1:0] dataP1_o,
    output logic [DW-1:0] dataP2_o,
    output logic [DW-1:0] dataP3_o,
    output logic [DW-1:0] dataM1_o,
    output logic [DW-1:0] dataM2_o,
    output logic [DW-1:0] dataM3_o,
    output logic          last_o,
    output logic          done_o
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    wr_ptr_q, wr_ptr_d;
    logic [4:0]    rd_idx_q, rd_idx_d;
    logic [DW-1:0] mem_q [N];

    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic [3:0]    count_q, count_d;
    logic [DW-1:0] d0_q, d0_d;
    logic [DW-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [DW-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;

    logic [3:0] n;
    logic       load_fire;
    logic       out_free;

    assign n         = rd_idx_q[3:0];
    assign in_ready  = (state_q == S_LOAD);
    assign load_fire = in_valid && in_ready;
    assign out_free  = !valid_q || out_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_idx_d = rd_idx_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;
        count_d  = count_q;
        d0_d     = d0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
        m1_d     = m1_q;
        m2_d     = m2_q;
        m3_d     = m3_q;
        unique case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    wr_ptr_d = wr_ptr_q + 4'd1;
                    if (wr_ptr_q == 4'd15) begin
                        state_d  = S_SWEEP;
                        wr_ptr_d = 4'd0;
                        rd_idx_d = 5'd0;
                    end
                end
            end
            S_SWEEP: begin
                if (out_free) begin
                    valid_d  = 1'b1;
                    rd_idx_d = rd_idx_q + 5'd1;
                    count_d  = n;
                    d0_d     = mem_q[n];
                    // taps that fall outside the frame are forced to zero
                    p1_d     = (n <= 4'd14) ? mem_q[n + 4'd1] : '0;
                    p2_d     = (n <= 4'd13) ? mem_q[n + 4'd2] : '0;
                    p3_d     = (n <= 4'd12) ? mem_q[n + 4'd3] : '0;
                    m1_d     = (n >= 4'd1) ? mem_q[n - 4'd1] : '0;
                    m2_d     = (n >= 4'd2) ? mem_q[n - 4'd2] : '0;
                    m3_d     = (n >= 4'd3) ? mem_q[n - 4'd3] : '0;
                    last_d   = (rd_idx_q == 5'd15);
                    if (rd_idx_q == 5'd15) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= 4'd0;
            rd_idx_q <= 5'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= 4'd0;
            d0_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            m1_q     <= '0;
            m2_q     <= '0;
            m3_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_idx_q <= rd_idx_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            count_q  <= count_d;
            d0_q     <= d0_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            m3_q     <= m3_d;
        end
    end

    // frame storage carries no reset; it is fully rewritten before each sweep
    always_ff @(posedge clk) begin
        if (!rst && load_fire) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = valid_q;
    assign count_o   = count_q;
    assign data0_o   = d0_q;
    assign dataP1_o  = p1_q;
    assign dataP2_o  = p2_q;
    assign dataP3_o  = p3_q;
    assign dataM1_o  = m1_q;
    assign dataM2_o  = m2_q;
    assign dataM3_o  = m3_q;
    assign last_o    = last_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_sample_window.sv
// tb_sample_window: randomized frames swept through sample_window and
// compared tap-by-tap against a frame-indexing reference model.
module tb_sample_window;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count_o;
    logic [31:0] data0_o;
    logic [31:0] dataP1_o, dataP2_o, dataP3_o;
    logic [31:0] dataM1_o, dataM2_o, dataM3_o;
    logic        last_o;
    logic        done_o;

    sample_window #(.DW(32), .N(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .count_o(count_o), .data0_o(data0_o),
        .dataP1_o(dataP1_o), .dataP2_o(dataP2_o), .dataP3_o(dataP3_o),
        .dataM1_o(dataM1_o), .dataM2_o(dataM2_o), .dataM3_o(dataM3_o),
        .last_o(last_o), .done_o(done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] frame [16];
    int          nb;
    logic [3:0]  b_cnt [32];
    logic        b_last [32];
    logic [31:0] b_tap [32][7];
    int          first_valid, done_cyc;
    bit          timeout, unstable, ready_in_sweep, ready_at_done, done_after;

    // x[n+k], zero outside the frame; index 0..6 maps to k = -3..+3
    function automatic logic [31:0] ref_tap(int n, int k);
        int idx;
        idx = n + k;
        if (idx < 0 || idx > 15) return 32'd0;
        return frame[idx];
    endfunction

    task automatic cur_taps(output logic [31:0] t [7]);
        t[0] = dataM3_o; t[1] = dataM2_o; t[2] = dataM1_o; t[3] = data0_o;
        t[4] = dataP1_o; t[5] = dataP2_o; t[6] = dataP3_o;
    endtask

    task automatic load_frame(input bit sparse, output int ready_low);
        int acc = 0;
        int guard = 0;
        ready_low = 0;
        while (acc < 16 && guard < 200) begin
            in_valid = sparse ? (guard % 2 == 0) : 1'b1;
            in_data  = frame[acc];
            if (!in_ready) ready_low++;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_at, input int stall_len, input bit foreign);
        int left = stall_len;
        bit snapped = 0;
        logic [31:0] snap [7];
        logic [31:0] cur [7];
        nb = 0; first_valid = -1; done_cyc = -1; timeout = 1; unstable = 0;
        ready_in_sweep = 0; ready_at_done = 0; done_after = 1;
        for (int i = 0; i < 32; i++) begin
            b_cnt[i] = 'x; b_last[i] = 'x;
            for (int k = 0; k < 7; k++) b_tap[i][k] = 'x;
        end
        for (int c = 0; c < 80; c++) begin
            cur_taps(cur);
            if (done_o) begin
                done_cyc = c; ready_at_done = in_ready; timeout = 0;
                in_valid = 1'b0; out_ready = 1'b1;
                @(posedge clk); #1;
                done_after = done_o;
                break;
            end
            if (in_ready) ready_in_sweep = 1;
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && count_o == 4'(stall_at) && (left > 0 || snapped)) begin
                if (!snapped) begin
                    snap = cur; snapped = 1;
                end else begin
                    for (int k = 0; k < 7; k++) if (cur[k] !== snap[k]) unstable = 1;
                end
            end
            out_ready = !(out_valid && count_o == 4'(stall_at) && left > 0);
            if (!out_ready) left--;
            if (out_valid && out_ready && nb < 32) begin
                b_cnt[nb] = count_o; b_last[nb] = last_o;
                for (int k = 0; k < 7; k++) b_tap[nb][k] = cur[k];
                nb++;
            end
            in_valid = foreign;
            in_data  = 32'hDEADBEEF;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] t [7];
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        cur_taps(t);
        for (int k = 0; k < 7; k++) begin
            tests_run++;
            if (t[k] !== 32'd0) begin tests_failed++; $display("FAIL reset_tap%0d got %h exp 0", k, t[k]); end
        end
        tests_run++;
        if ({out_valid, last_o, done_o, count_o} !== 7'd0) begin
            tests_failed++; $display("FAIL reset_ctrl got v%b l%b d%b c%0d exp 0", out_valid, last_o, done_o, count_o);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_ramp;
        int rl;
        for (int i = 0; i < 16; i++) frame[i] = 32'(i + 1);
        load_frame(0, rl);
        collect(0, 0, 0);
        tests_run++;
        if (nb !== 16 || timeout) begin tests_failed++; $display("FAIL ramp_beats got %0d exp 16 (timeout %0b)", nb, timeout); end
        tests_run++;
        if (first_valid !== 1) begin tests_failed++; $display("FAIL ramp_latency got %0d exp 1", first_valid); end
        tests_run++;
        if (done_cyc !== 17 || done_after !== 1'b0) begin
            tests_failed++; $display("FAIL ramp_done got cyc %0d after %b exp 17/0", done_cyc, done_after);
        end
        tests_run++;
        if (ready_in_sweep || !ready_at_done) begin
            tests_failed++; $display("FAIL ramp_in_ready got sweep %b done %b exp 0/1", ready_in_sweep, ready_at_done);
        end
        for (int b = 0; b < 16; b++) begin
            tests_run++;
            if (b_cnt[b] !== 4'(b) || b_last[b] !== (b == 15)) begin
                tests_failed++; $display("FAIL ramp_idx%0d got c%0d l%b exp c%0d l%b", b, b_cnt[b], b_last[b], b, b == 15);
            end
            for (int k = -3; k <= 3; k++) begin
                tests_run++;
                if (b_tap[b][k+3] !== ref_tap(b, k)) begin
                    tests_failed++; $display("FAIL ramp_n%0d_k%0d got %h exp %h", b, k, b_tap[b][k+3], ref_tap(b, k));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int rl;
        for (int i = 0; i < 16; i++) frame[i] = $urandom;
        load_frame(0, rl);
        collect(5, 3, 0);
        tests_run++;
        if (nb !== 16) begin tests_failed++; $display("FAIL bp_beats got %0d exp 16", nb); end
        tests_run++;
        if (unstable) begin tests_failed++; $display("FAIL bp_stable got unstable exp stable"); end
        tests_run++;
        if (done_cyc !== 20) begin tests_failed++; $display("FAIL bp_done got %0d exp 20", done_cyc); end
        for (int b = 0; b < 16; b++) begin
            tests_run++;
            if (b_cnt[b] !== 4'(b)) begin tests_failed++; $display("FAIL bp_idx%0d got %0d exp %0d", b, b_cnt[b], b); end
            for (int k = -3; k <= 3; k++) begin
                tests_run++;
                if (b_tap[b][k+3] !== ref_tap(b, k)) begin
                    tests_failed++; $display("FAIL bp_n%0d_k%0d got %h exp %h", b, k, b_tap[b][k+3], ref_tap(b, k));
                end
            end
        end
    endtask

    task automatic test_sparse;
        int rl;
        for (int i = 0; i < 16; i++) frame[i] = 32'(i + 1);
        load_frame(1, rl);
        collect(0, 0, 0);
        tests_run++;
        if (rl !== 0) begin tests_failed++; $display("FAIL sparse_in_ready got %0d low cycles exp 0", rl); end
        tests_run++;
        if (first_valid !== 1) begin tests_failed++; $display("FAIL sparse_latency got %0d exp 1", first_valid); end
        for (int b = 0; b < 16; b++) begin
            for (int k = -3; k <= 3; k++) begin
                tests_run++;
                if (b_tap[b][k+3] !== ref_tap(b, k) || b_cnt[b] !== 4'(b)) begin
                    tests_failed++; $display("FAIL sparse_n%0d_k%0d got %h exp %h", b, k, b_tap[b][k+3], ref_tap(b, k));
                end
            end
        end
    endtask

    task automatic test_foreign;
        int rl;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) frame[i] = $urandom;
            load_frame(0, rl);
            collect(0, 0, r == 0);
            tests_run++;
            if (ready_in_sweep || nb !== 16) begin
                tests_failed++; $display("FAIL foreign%0d_ctrl got ready %b beats %0d exp 0/16", r, ready_in_sweep, nb);
            end
            for (int b = 0; b < 16; b++) begin
                for (int k = -3; k <= 3; k++) begin
                    tests_run++;
                    if (b_tap[b][k+3] !== ref_tap(b, k)) begin
                        tests_failed++; $display("FAIL foreign%0d_n%0d_k%0d got %h exp %h", r, b, k, b_tap[b][k+3], ref_tap(b, k));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int rl;
        int g = 0;
        logic [31:0] t [7];
        for (int i = 0; i < 16; i++) frame[i] = $urandom;
        load_frame(0, rl);
        out_ready = 1'b1;
        while (!(out_valid && count_o == 4'd7) && g < 40) begin
            @(posedge clk); #1; g++;
        end
        tests_run++;
        if (g >= 40) begin tests_failed++; $display("FAIL rstmid_reach got timeout exp n=7"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cur_taps(t);
        for (int k = 0; k < 7; k++) begin
            tests_run++;
            if (t[k] !== 32'd0) begin tests_failed++; $display("FAIL rstmid_tap%0d got %h exp 0", k, t[k]); end
        end
        tests_run++;
        if ({out_valid, last_o, done_o, count_o} !== 7'd0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_ctrl got v%b l%b d%b c%0d r%b exp 0/1", out_valid, last_o, done_o, count_o, in_ready);
        end
        for (int i = 0; i < 16; i++) frame[i] = 32'(100 + i);
        load_frame(0, rl);
        collect(0, 0, 0);
        for (int b = 0; b < 16; b++) begin
            for (int k = -3; k <= 3; k++) begin
                tests_run++;
                if (b_tap[b][k+3] !== ref_tap(b, k) || b_cnt[b] !== 4'(b)) begin
                    tests_failed++; $display("FAIL rstmid_n%0d_k%0d got %h exp %h", b, k, b_tap[b][k+3], ref_tap(b, k));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int rl;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) frame[i] = (i % 2 == r) ? 32'h80000000 : 32'h7FFFFFFF;
            load_frame(0, rl);
            collect(0, 0, 0);
            tests_run++;
            if (done_cyc !== 17 || nb !== 16) begin
                tests_failed++; $display("FAIL b2b%0d_done got cyc %0d beats %0d exp 17/16", r, done_cyc, nb);
            end
            for (int b = 0; b < 16; b++) begin
                for (int k = -3; k <= 3; k++) begin
                    tests_run++;
                    if (b_tap[b][k+3] !== ref_tap(b, k)) begin
                        tests_failed++; $display("FAIL b2b%0d_n%0d_k%0d got %h exp %h", r, b, k, b_tap[b][k+3], ref_tap(b, k));
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset;
        test_ramp;
        test_backpressure;
        test_sparse;
        test_foreign;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
